hazard_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage CPU. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve: load-use stalls, taken-branch/jump flushes, and multi-cycle data-memory waits. It drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error.

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer: load-use stalls, branch/jump flushes,
// multi-cycle data-memory waits with timeout, stall-cycle statistics.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegRT_i,
    input  logic [4:0]       IFID_RegRS_i,
    input  logic [4:0]       IFID_RegRT_i,
    input  logic             Branch_i,
    input  logic             Jump_i,
    input  logic             DMem_req_i,
    input  logic             DMem_ack_i,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             Freeze_o,
    output logic             MEMWB_Bubble_o,
    output logic             Error_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_e             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_stall;
    logic               load_use;

    assign mem_stall = ((state_q == RUN) && DMem_req_i && !DMem_ack_i)
                     || ((state_q == MEM_WAIT) && !DMem_ack_i)
                     || (state_q == ERROR);

    assign load_use = IDEX_MemRead_i && (IDEX_RegRT_i != 5'd0)
                    && ((IDEX_RegRT_i == IFID_RegRS_i)
                        || (IDEX_RegRT_i == IFID_RegRT_i));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        error_d = error_q;
        unique case (state_q)
            RUN: begin
                if (DMem_req_i && !DMem_ack_i) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (DMem_ack_i) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == TIMEOUT) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ERROR: begin
                // Only reset leaves ERROR; late acks are dropped.
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((mem_stall || load_use) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory stall outranks load-use, which outranks control flushes.
    always_comb begin
        PCWrite_o      = 1'b1;
        IFID_Write_o   = 1'b1;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b0;
        Freeze_o       = 1'b0;
        MEMWB_Bubble_o = 1'b0;
        if (!rst_i) begin
            PCWrite_o      = 1'b0;
            IFID_Write_o   = 1'b0;
            IFID_Flush_o   = 1'b1;
            IDEX_Bubble_o  = 1'b1;
            MEMWB_Bubble_o = 1'b1;
        end else if (mem_stall) begin
            PCWrite_o      = 1'b0;
            IFID_Write_o   = 1'b0;
            Freeze_o       = 1'b1;
            MEMWB_Bubble_o = 1'b1;
        end else if (load_use) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (Branch_i || Jump_i) begin
            IFID_Flush_o = 1'b1;
        end
    end

    assign Error_o    = error_q;
    assign StallCnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       mr = 1'b0;
    logic [4:0] exrt = 5'd0;
    logic [4:0] rs = 5'd0;
    logic [4:0] rt = 5'd0;
    logic       br = 1'b0;
    logic       jp = 1'b0;
    logic       req = 1'b0;
    logic       ack = 1'b0;
    logic       pcw, ifw, flush, bub, frz, mwb, err;
    logic [3:0] cnt;

    typedef struct {
        int         id;
        logic [6:0] ctl;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sid      = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (mr),
        .IDEX_RegRT_i   (exrt),
        .IFID_RegRS_i   (rs),
        .IFID_RegRT_i   (rt),
        .Branch_i       (br),
        .Jump_i         (jp),
        .DMem_req_i     (req),
        .DMem_ack_i     (ack),
        .PCWrite_o      (pcw),
        .IFID_Write_o   (ifw),
        .IFID_Flush_o   (flush),
        .IDEX_Bubble_o  (bub),
        .Freeze_o       (frz),
        .MEMWB_Bubble_o (mwb),
        .Error_o        (err),
        .StallCnt_o     (cnt)
    );

    always #5 clk_i = ~clk_i;

    // ctl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Freeze, MEMWB_Bubble, Error}
    task automatic step(
        input logic       r,
        input logic       m,
        input logic [4:0] e,
        input logic [4:0] s,
        input logic [4:0] t,
        input logic       b,
        input logic       j,
        input logic       rq,
        input logic       ak,
        input logic [6:0] ctl,
        input logic [3:0] c
    );
        exp_t x;
        @(posedge clk_i);
        #1;
        rst_i = r;
        mr    = m;
        exrt  = e;
        rs    = s;
        rt    = t;
        br    = b;
        jp    = j;
        req   = rq;
        ack   = ak;
        sid++;
        x.id  = sid;
        x.ctl = ctl;
        x.cnt = c;
        q.push_back(x);
    endtask

    always @(negedge clk_i) begin
        exp_t x;
        logic [6:0] act;
        if (q.size() > 0) begin
            x   = q.pop_front();
            act = {pcw, ifw, flush, bub, frz, mwb, err};
            n_checks++;
            if (act !== x.ctl || cnt !== x.cnt) begin
                n_fail++;
                $display("FAIL step%0d ctl/cnt: got %b/%0d expected %b/%0d",
                         x.id, act, cnt, x.ctl, x.cnt);
            end
        end
    end

    initial begin
        // reset and idle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011010, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd0);
        // load-use on rs, one-cycle stall
        step(1, 1, 5, 5, 0, 0, 0, 0, 0, 7'b0001000, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd1);
        // r0 destination never stalls
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd1);
        // load-use on rt beats branch, then branch flushes, then jump
        step(1, 1, 7, 3, 7, 1, 0, 0, 0, 7'b0001000, 4'd1);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 7'b1110000, 4'd2);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1110000, 4'd2);
        // zero-wait access stays in RUN
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1100000, 4'd2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd2);
        // 3-cycle wait, load-use + branch ignored while frozen
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 4'd2);
        step(1, 1, 9, 9, 0, 1, 0, 1, 0, 7'b0000110, 4'd3);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 4'd4);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1100000, 4'd5);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd5);
        // reset clears count asynchronously
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011010, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd0);
        // timeout: wait counter 1..4 in MEM_WAIT, then ERROR
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 4'd1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 4'd2);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 4'd3);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 4'd4);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000111, 4'd5);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000111, 4'd6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000111, 4'd7);
        // mid-cycle reset out of ERROR, back to RUN
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011010, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd0);
        // saturation: 21 stalled cycles, ERROR from cycle 5 on
        for (int i = 0; i < 21; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 1, 0,
                 {6'b000011, (i >= 5)},
                 (i > 15) ? 4'd15 : 4'(i));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011010, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 4'd0);
        repeat (3) @(posedge clk_i);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
